// File: rtl/sdc_pkg.sv
// Shared constants for the SD controller transfer sequencer: state encoding,
// data path event bit positions and status byte bit positions.
package sdc_pkg;

   typedef logic [2:0] seqStateT;

   localparam seqStateT ST_IDLE     = 3'd0;
   localparam seqStateT ST_START    = 3'd1;
   localparam seqStateT ST_WAIT_RUN = 3'd2;
   localparam seqStateT ST_RUN      = 3'd3;
   localparam seqStateT ST_STOP     = 3'd4;
   localparam seqStateT ST_BUSY     = 3'd5;
   localparam seqStateT ST_DONE     = 3'd6;

   localparam int EV_OK  = 0;
   localparam int EV_ANY = 1;
   localparam int EV_CRC = 2;
   localparam int EV_OVF = 3;
   localparam int EV_UDF = 4;
   localparam int EV_FRM = 5;
   localparam int EV_TMO = 6;

   localparam int SB_OK      = 0;
   localparam int SB_CRC     = 1;
   localparam int SB_OVF     = 2;
   localparam int SB_UDF     = 3;
   localparam int SB_FRM     = 4;
   localparam int SB_TMO     = 5;
   localparam int SB_STOPERR = 6;
   localparam int SB_FAIL    = 7;

endpackage

// File: rtl/sdc_transfer_sequencer.sv
// Block-transfer sequencer feeding the SD data path. Build with SDC_SEQ_AUTO_STOP_EN
// defined to enable the automatic CMD12 (STOP) path; without it stop_req stays 0.
module sdc_transfer_sequencer #(
   parameter int BLKCNT_W   = 16,
   parameter int START_WAIT = 4
) (
   input  logic                sd_clk,
   input  logic                sd_rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [BLKCNT_W-1:0] req_blkcnt,
   input  logic                req_auto_stop,
   input  logic                abort,
   output logic                dp_rxStart,
   output logic                dp_txStart,
   output logic [BLKCNT_W-1:0] dp_blockCount,
   input  logic [6:0]          dp_events,
   input  logic                dp_sdBusy,
   output logic                stop_req,
   input  logic                stop_ack,
   input  logic                stop_err,
   output logic [7:0]          status,
   output logic                irq,
   input  logic                irq_clr
);
   import sdc_pkg::*;

`ifdef SDC_SEQ_AUTO_STOP_EN
   localparam logic AUTO_STOP_EN = 1'b1;
`else
   localparam logic AUTO_STOP_EN = 1'b0;
`endif

   localparam int WD_W = $clog2(START_WAIT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(START_WAIT - 1);

   seqStateT            state, stateNext;
   logic                isWrite, writeNext;
   logic                autoStop, autoNext;
   logic                abortSeen, abortNext;
   logic [WD_W-1:0]     wdCnt, wdNext;
   logic [7:0]          statusReg, statusNext;
   logic                irqReg, irqNext;
   logic                readyReg, readyNext;
   logic                rxStartReg, rxNext;
   logic                txStartReg, txNext;
   logic                stopReq, stopNext;
   logic [BLKCNT_W-1:0] blockCount, countNext;
   logic                dpError;

   assign dpError = |dp_events[EV_TMO:EV_ANY];

   // Next-state and next-output logic; every output is registered so nothing glitches out of reset.
   always_comb begin
      stateNext  = state;
      writeNext  = isWrite;
      autoNext   = autoStop;
      abortNext  = abortSeen;
      wdNext     = wdCnt;
      statusNext = statusReg;
      irqNext    = irqReg;
      rxNext     = 1'b0;
      txNext     = 1'b0;
      stopNext   = stopReq;
      countNext  = blockCount;

      // A DONE entry outranks a coincident clear.
      if (irq_clr && state != ST_DONE) begin
         irqNext    = 1'b0;
         statusNext = '0;
      end

      case (state)
         ST_IDLE: begin
            if (req_valid && readyReg) begin
               writeNext = req_write;
               countNext = req_blkcnt;
               autoNext  = req_auto_stop & AUTO_STOP_EN;
               abortNext = 1'b0;
               wdNext    = '0;
               if (req_blkcnt == '0) begin
                  statusNext[SB_FAIL] = 1'b1;
                  stateNext           = ST_DONE;
               end else begin
                  rxNext    = ~req_write;
                  txNext    = req_write;
                  stateNext = ST_START;
               end
            end
         end
         ST_START: begin
            wdNext    = '0;
            stateNext = ST_WAIT_RUN;
         end
         ST_WAIT_RUN: begin
            if (abort) begin
               statusNext[SB_FAIL] = 1'b1;
               abortNext           = 1'b1;
            end
            if (dp_events == '0) begin
               stateNext = ST_RUN;
            end else if (wdCnt == WD_LAST) begin
               statusNext[SB_FAIL] = 1'b1;
               stateNext           = ST_DONE;
            end else begin
               wdNext = wdCnt + WD_W'(1);
            end
         end
         ST_RUN: begin
            if (abort) begin
               statusNext[SB_FAIL] = 1'b1;
               abortNext           = 1'b1;
            end
            if (dp_events != '0) begin
               statusNext[SB_TMO:SB_CRC] = statusNext[SB_TMO:SB_CRC] | dp_events[EV_TMO:EV_CRC];
               statusNext[SB_OK]         = statusNext[SB_OK] | dp_events[EV_OK];
               // An abort or a data path error always takes the CMD12 path when it exists.
               if (AUTO_STOP_EN && ((autoStop && blockCount > BLKCNT_W'(1)) || dpError || abortNext)) begin
                  stopNext  = 1'b1;
                  stateNext = ST_STOP;
               end else if (isWrite) begin
                  stateNext = ST_BUSY;
               end else begin
                  stateNext = ST_DONE;
               end
            end
         end
         ST_STOP: begin
            if (stop_ack) begin
               statusNext[SB_STOPERR] = statusNext[SB_STOPERR] | stop_err;
               stopNext               = 1'b0;
               stateNext              = isWrite ? ST_BUSY : ST_DONE;
            end
         end
         ST_BUSY: begin
            if (!dp_sdBusy) begin
               stateNext = ST_DONE;
            end
         end
         ST_DONE: begin
            irqNext   = 1'b1;
            stateNext = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase

      readyNext = (stateNext == ST_IDLE) && !irqNext;
   end

   // State and output registers.
   always_ff @(posedge sd_clk or negedge sd_rst_n) begin
      if (!sd_rst_n) begin
         state      <= ST_IDLE;
         isWrite    <= 1'b0;
         autoStop   <= 1'b0;
         abortSeen  <= 1'b0;
         wdCnt      <= '0;
         statusReg  <= '0;
         irqReg     <= 1'b0;
         readyReg   <= 1'b0;
         rxStartReg <= 1'b0;
         txStartReg <= 1'b0;
         stopReq    <= 1'b0;
         blockCount <= '0;
      end else begin
         state      <= stateNext;
         isWrite    <= writeNext;
         autoStop   <= autoNext;
         abortSeen  <= abortNext;
         wdCnt      <= wdNext;
         statusReg  <= statusNext;
         irqReg     <= irqNext;
         readyReg   <= readyNext;
         rxStartReg <= rxNext;
         txStartReg <= txNext;
         stopReq    <= stopNext;
         blockCount <= countNext;
      end
   end

   assign req_ready     = readyReg;
   assign dp_rxStart    = rxStartReg;
   assign dp_txStart    = txStartReg;
   assign dp_blockCount = blockCount;
   assign stop_req      = stopReq & AUTO_STOP_EN;
   assign status        = statusReg;
   assign irq           = irqReg;

endmodule

// File: tb/tb_sdc_transfer_sequencer.sv
// Directed self-checking bench for sdc_transfer_sequencer; expected values follow
// whether SDC_SEQ_AUTO_STOP_EN is defined for the build.
module tb_sdc_transfer_sequencer;

   localparam int BLKCNT_W   = 16;
   localparam int START_WAIT = 4;

`ifdef SDC_SEQ_AUTO_STOP_EN
   localparam logic [7:0] EXP_T3_STATUS = 8'h42;
   localparam int         EXP_T2_STOP   = 10;
`else
   localparam logic [7:0] EXP_T3_STATUS = 8'h02;
   localparam int         EXP_T2_STOP   = 0;
`endif

   logic                sd_clk = 1'b0;
   logic                sd_rst_n;
   logic                req_valid;
   logic                req_ready;
   logic                req_write;
   logic [BLKCNT_W-1:0] req_blkcnt;
   logic                req_auto_stop;
   logic                abort;
   logic                dp_rxStart;
   logic                dp_txStart;
   logic [BLKCNT_W-1:0] dp_blockCount;
   logic [6:0]          dp_events;
   logic                dp_sdBusy;
   logic                stop_req;
   logic                stop_ack;
   logic                stop_err;
   logic [7:0]          status;
   logic                irq;
   logic                irq_clr;

   int assertCount = 0;
   int failCount   = 0;
   int rxPulses    = 0;
   int txPulses    = 0;
   int stopCycles  = 0;
   int rxBase, txBase, stopBase;

   sdc_transfer_sequencer #(
      .BLKCNT_W   (BLKCNT_W),
      .START_WAIT (START_WAIT)
   ) dut (
      .sd_clk        (sd_clk),
      .sd_rst_n      (sd_rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_blkcnt    (req_blkcnt),
      .req_auto_stop (req_auto_stop),
      .abort         (abort),
      .dp_rxStart    (dp_rxStart),
      .dp_txStart    (dp_txStart),
      .dp_blockCount (dp_blockCount),
      .dp_events     (dp_events),
      .dp_sdBusy     (dp_sdBusy),
      .stop_req      (stop_req),
      .stop_ack      (stop_ack),
      .stop_err      (stop_err),
      .status        (status),
      .irq           (irq),
      .irq_clr       (irq_clr)
   );

   always #5 sd_clk = ~sd_clk;

   // Pulse and stop_req activity, sampled mid-cycle.
   always @(negedge sd_clk) begin
      if (dp_rxStart) rxPulses++;
      if (dp_txStart) txPulses++;
      if (stop_req)   stopCycles++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(negedge sd_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic write, input logic [BLKCNT_W-1:0] cnt, input logic autoStop);
      req_valid     = 1'b1;
      req_write     = write;
      req_blkcnt    = cnt;
      req_auto_stop = autoStop;
      tick();
      req_valid     = 1'b0;
   endtask

   task automatic clearIrq(input string tag);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      checkOutput({tag, " irq cleared"}, irq, 1'b0);
      checkOutput({tag, " status cleared"}, status, 8'h00);
      checkOutput({tag, " ready after clear"}, req_ready, 1'b1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " req_ready"}, req_ready, 1'b0);
      checkOutput({tag, " rxStart"}, dp_rxStart, 1'b0);
      checkOutput({tag, " txStart"}, dp_txStart, 1'b0);
      checkOutput({tag, " blockCount"}, dp_blockCount, 16'h0000);
      checkOutput({tag, " stop_req"}, stop_req, 1'b0);
      checkOutput({tag, " status"}, status, 8'h00);
      checkOutput({tag, " irq"}, irq, 1'b0);
   endtask

   task automatic markCounters();
      rxBase   = rxPulses;
      txBase   = txPulses;
      stopBase = stopCycles;
   endtask

   initial begin
      sd_rst_n      = 1'b0;
      req_valid     = 1'b0;
      req_write     = 1'b0;
      req_blkcnt    = '0;
      req_auto_stop = 1'b0;
      abort         = 1'b0;
      dp_events     = 7'h01;
      dp_sdBusy     = 1'b0;
      stop_ack      = 1'b0;
      stop_err      = 1'b0;
      irq_clr       = 1'b0;

      tick();
      checkAllZero("reset");
      sd_rst_n = 1'b1;
      tick();
      checkOutput("ready after reset", req_ready, 1'b1);

      // RX, one block, clean finish
      markCounters();
      applyStimulus(1'b0, 16'd1, 1'b0);
      checkOutput("t1 rxStart", dp_rxStart, 1'b1);
      checkOutput("t1 txStart", dp_txStart, 1'b0);
      checkOutput("t1 blockCount", dp_blockCount, 16'd1);
      checkOutput("t1 ready low", req_ready, 1'b0);
      dp_events = 7'h00;
      tick();
      checkOutput("t1 rxStart one cycle", dp_rxStart, 1'b0);
      tick();
      dp_events = 7'h01;
      tick();
      checkOutput("t1 status latched", status, 8'h01);
      checkOutput("t1 irq in done", irq, 1'b0);
      tick();
      checkOutput("t1 irq", irq, 1'b1);
      checkOutput("t1 status", status, 8'h01);
      checkOutput("t1 ready while irq", req_ready, 1'b0);
      checkOutput("t1 rx pulses", rxPulses - rxBase, 1);
      checkOutput("t1 stop cycles", stopCycles - stopBase, 0);
      clearIrq("t1");

      // TX, four blocks, auto stop, card busy afterwards
      markCounters();
      dp_sdBusy = 1'b1;
      applyStimulus(1'b1, 16'd4, 1'b1);
      checkOutput("t2 txStart", dp_txStart, 1'b1);
      checkOutput("t2 rxStart", dp_rxStart, 1'b0);
      checkOutput("t2 blockCount", dp_blockCount, 16'd4);
      dp_events = 7'h00;
      tick();
      tick();
      dp_events = 7'h01;
      tick();
`ifdef SDC_SEQ_AUTO_STOP_EN
      checkOutput("t2 stop_req rise", stop_req, 1'b1);
      repeat (9) tick();
      checkOutput("t2 stop_req held", stop_req, 1'b1);
      stop_ack = 1'b1;
      tick();
      stop_ack = 1'b0;
      checkOutput("t2 stop_req fall", stop_req, 1'b0);
`else
      checkOutput("t2 stop_req tied", stop_req, 1'b0);
`endif
      repeat (20) tick();
      checkOutput("t2 irq while busy", irq, 1'b0);
      checkOutput("t2 blockCount held", dp_blockCount, 16'd4);
      dp_sdBusy = 1'b0;
      tick();
      checkOutput("t2 irq in done", irq, 1'b0);
      tick();
      checkOutput("t2 irq", irq, 1'b1);
      checkOutput("t2 status", status, 8'h01);
      checkOutput("t2 tx pulses", txPulses - txBase, 1);
      checkOutput("t2 stop cycles", stopCycles - stopBase, EXP_T2_STOP);
      clearIrq("t2");

      // RX, eight blocks, CRC error without auto stop
      applyStimulus(1'b0, 16'd8, 1'b0);
      checkOutput("t3 rxStart", dp_rxStart, 1'b1);
      dp_events = 7'h00;
      tick();
      tick();
      dp_events = 7'h06;
      tick();
      checkOutput("t3 status latched", status, 8'h02);
`ifdef SDC_SEQ_AUTO_STOP_EN
      checkOutput("t3 stop_req on error", stop_req, 1'b1);
      stop_ack = 1'b1;
      stop_err = 1'b1;
      tick();
      stop_ack = 1'b0;
      stop_err = 1'b0;
      checkOutput("t3 stop_req fall", stop_req, 1'b0);
`else
      checkOutput("t3 stop_req tied", stop_req, 1'b0);
`endif
      tick();
      checkOutput("t3 irq", irq, 1'b1);
      checkOutput("t3 status", status, EXP_T3_STATUS);
      dp_events = 7'h01;
      clearIrq("t3");

      // Data path never reports running: watchdog expiry
      applyStimulus(1'b0, 16'd2, 1'b0);
      tick();
      repeat (3) tick();
      checkOutput("t4 status before expiry", status, 8'h00);
      checkOutput("t4 irq before expiry", irq, 1'b0);
      tick();
      checkOutput("t4 status at expiry", status, 8'h80);
      tick();
      checkOutput("t4 irq", irq, 1'b1);
      repeat (3) tick();
      checkOutput("t4 ready held low", req_ready, 1'b0);
      checkOutput("t4 irq level", irq, 1'b1);
      clearIrq("t4");

      // Zero block count is rejected without a start pulse
      markCounters();
      applyStimulus(1'b1, 16'd0, 1'b0);
      checkOutput("t5a status", status, 8'h80);
      checkOutput("t5a irq in done", irq, 1'b0);
      tick();
      checkOutput("t5a irq", irq, 1'b1);
      checkOutput("t5a no pulse", (rxPulses - rxBase) + (txPulses - txBase), 0);
      clearIrq("t5a");

      // Abort during RUN, data path then finishes cleanly
      applyStimulus(1'b0, 16'd1, 1'b0);
      dp_events = 7'h00;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("t5b status after abort", status, 8'h80);
      checkOutput("t5b irq still low", irq, 1'b0);
      dp_events = 7'h01;
      tick();
      checkOutput("t5b status latched", status, 8'h81);
`ifdef SDC_SEQ_AUTO_STOP_EN
      checkOutput("t5b stop_req forced", stop_req, 1'b1);
      stop_ack = 1'b1;
      abort    = 1'b1;
      tick();
      stop_ack = 1'b0;
      abort    = 1'b0;
      checkOutput("t5b stop_req fall", stop_req, 1'b0);
`endif
      tick();
      checkOutput("t5b irq", irq, 1'b1);
      checkOutput("t5b status", status, 8'h81);
      clearIrq("t5b");

      // Reset in the middle of a transfer
      applyStimulus(1'b1, 16'd4, 1'b1);
      dp_events = 7'h00;
      tick();
      tick();
`ifdef SDC_SEQ_AUTO_STOP_EN
      dp_events = 7'h01;
      tick();
      checkOutput("t6 stop_req pending", stop_req, 1'b1);
`else
      checkOutput("t6 blockCount mid run", dp_blockCount, 16'd4);
`endif
      sd_rst_n = 1'b0;
      #1;
      checkAllZero("t6 async reset");
      dp_events = 7'h01;
      tick();
      markCounters();
      sd_rst_n = 1'b1;
      tick();
      checkOutput("t6 ready after release", req_ready, 1'b1);
      checkOutput("t6 no glitch", (rxPulses - rxBase) + (txPulses - txBase) + (stopCycles - stopBase), 0);
      applyStimulus(1'b0, 16'd3, 1'b0);
      checkOutput("t6 rxStart", dp_rxStart, 1'b1);
      checkOutput("t6 blockCount", dp_blockCount, 16'd3);
      dp_events = 7'h00;
      tick();
      tick();
      dp_events = 7'h01;
      tick();
      tick();
      checkOutput("t6 irq", irq, 1'b1);
      checkOutput("t6 status", status, 8'h01);
      clearIrq("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
